// File: rtl/ack_bus_pkg.sv
// Shared ack-bus definitions: source IDs and requester FSM state.
// Used by every requester and by the ack-bus arbiter top.
package ack_bus_pkg;

  localparam logic [1:0] ID_MEM  = 2'b00;
  localparam logic [1:0] ID_SHA  = 2'b01;
  localparam logic [1:0] ID_AES  = 2'b10;
  localparam logic [1:0] ID_CTRL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_GAP  = 2'b10
  } req_state_e;

  function automatic logic id_match(
    input logic [1:0] winner,
    input logic [1:0] self
  );
    return winner == self;
  endfunction

endpackage

// File: rtl/ack_req_timer.sv
// Grant-wait timer: counts consecutive cycles of active_i.
// Ports: clk, rst (async high), active_i, hit_o (limit reached this cycle).
module ack_req_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic active_i,
  output logic hit_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIM = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] PRE = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Any inactive cycle (grant or leaving REQ) restarts the count;
  // the count saturates so a long stall never wraps.
  always_comb begin
    cnt_d = '0;
    if (active_i) begin
      cnt_d = (cnt_q == LIM) ? cnt_q : cnt_q + CW'(1);
    end
  end

  assign hit_o = active_i && (cnt_q == PRE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ack_bus_requester.sv
// Per-source ack-bus requester: queues ack pulses, requests the bus,
// delivers one ack per grant with a one-cycle gap between grants.
// Ports: clk, rst (async high), ack_pulse_i, ack_ready_i,
//   winner_source_id_i, ack_event_i, req_o, ack_sent_o, pending_o,
//   overflow_o, proto_err_o, timeout_o.
// Optional: define ACK_REQ_TIMEOUT_EN to enable the grant-wait timer.
module ack_bus_requester
  import ack_bus_pkg::*;
#(
  parameter logic [1:0] SOURCE_ID      = 2'b00,
  parameter int         PEND_W         = 2,
  parameter int         TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ack_pulse_i,
  input  logic              ack_ready_i,
  input  logic [1:0]        winner_source_id_i,
  input  logic              ack_event_i,
  output logic              req_o,
  output logic              ack_sent_o,
  output logic [PEND_W-1:0] pending_o,
  output logic              overflow_o,
  output logic              proto_err_o,
  output logic              timeout_o
);

  req_state_e        state_q, state_d;
  logic [PEND_W-1:0] pending_q, pending_d;
  logic              ack_sent_q, ack_sent_d;
  logic              overflow_q, overflow_d;
  logic              proto_err_q, proto_err_d;

  logic in_req;
  logic grant;
  logic full;
  logic push;

  assign in_req = (state_q == ST_REQ);
  assign grant  = in_req && ack_ready_i && ack_event_i
               && id_match(winner_source_id_i, SOURCE_ID);
  assign full   = (pending_q == {PEND_W{1'b1}});
  // At capacity a push is still accepted if a grant frees a slot.
  assign push   = ack_pulse_i && (!full || grant);

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q + PEND_W'(push) - PEND_W'(grant);
    ack_sent_d  = grant;
    overflow_d  = overflow_q || (ack_pulse_i && !push);
    // READY that is not a valid grant is a protocol violation,
    // whether mismatched in REQ or seen in any other state.
    proto_err_d = proto_err_q || (ack_ready_i && !grant);
    unique case (state_q)
      ST_IDLE: begin
        if (pending_q != '0 || ack_pulse_i) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (grant) state_d = ST_GAP;
      end
      ST_GAP: begin
        state_d = (pending_d != '0) ? ST_REQ : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pending_q   <= '0;
      ack_sent_q  <= 1'b0;
      overflow_q  <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      ack_sent_q  <= ack_sent_d;
      overflow_q  <= overflow_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign req_o       = in_req;
  assign ack_sent_o  = ack_sent_q;
  assign pending_o   = pending_q;
  assign overflow_o  = overflow_q;
  assign proto_err_o = proto_err_q;

`ifdef ACK_REQ_TIMEOUT_EN
  logic timeout_q, timeout_d;
  logic to_hit;

  ack_req_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .active_i(in_req && !grant),
    .hit_o   (to_hit)
  );

  always_comb begin
    timeout_d = timeout_q || to_hit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_ack_bus_requester.sv
// Directed bench for ack_bus_requester (SOURCE_ID=01, PEND_W=2,
// TIMEOUT_CYCLES=8) with an ack scoreboard.
module tb_ack_bus_requester;

  localparam logic [1:0] SID = 2'b01;

  logic       clk = 1'b0;
  logic       rst;
  logic       ack_pulse_i;
  logic       ack_ready_i;
  logic [1:0] winner_source_id_i;
  logic       ack_event_i;
  logic       req_o;
  logic       ack_sent_o;
  logic [1:0] pending_o;
  logic       overflow_o;
  logic       proto_err_o;
  logic       timeout_o;

  int tests = 0;
  int fails = 0;
  int mdl_pend = 0;
  int sbq[$];

  always #5 clk = ~clk;

  ack_bus_requester #(
    .SOURCE_ID     (SID),
    .PEND_W        (2),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .ack_pulse_i       (ack_pulse_i),
    .ack_ready_i       (ack_ready_i),
    .winner_source_id_i(winner_source_id_i),
    .ack_event_i       (ack_event_i),
    .req_o             (req_o),
    .ack_sent_o        (ack_sent_o),
    .pending_o         (pending_o),
    .overflow_o        (overflow_o),
    .proto_err_o       (proto_err_o),
    .timeout_o         (timeout_o)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, update the model, sample at edge+1.
  task automatic cyc(
    input logic       p,
    input logic       r,
    input logic [1:0] w,
    input logic       e
  );
    logic g;
    logic pk;
    ack_pulse_i        = p;
    ack_ready_i        = r;
    winner_source_id_i = w;
    ack_event_i        = e;
    g  = req_o && r && e && (w == SID);
    pk = p && (mdl_pend != 3 || g);
    mdl_pend = mdl_pend + int'(pk) - int'(g);
    if (g) sbq.push_back(mdl_pend);
    @(posedge clk);
    #1;
    ack_pulse_i        = 1'b0;
    ack_ready_i        = 1'b0;
    winner_source_id_i = 2'b00;
    ack_event_i        = 1'b0;
    if (g) chk("ack_expected", ack_sent_o, 1);
    if (ack_sent_o) begin
      if (sbq.size() == 0) chk("sb_unexp", ack_sent_o, 0);
      else chk("sb_pend", pending_o, sbq.pop_front());
    end
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 2'b00, 1'b0);
  endtask

  task automatic grant();
    cyc(1'b0, 1'b1, SID, 1'b1);
  endtask

  initial begin
    int acks;
    int last;
    rst                = 1'b1;
    ack_pulse_i        = 1'b0;
    ack_ready_i        = 1'b0;
    winner_source_id_i = 2'b00;
    ack_event_i        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", req_o, 0);
    chk("rst_pend", pending_o, 0);
    chk("rst_sent", ack_sent_o, 0);
    chk("rst_flags", {overflow_o, proto_err_o, timeout_o}, 0);
    rst = 1'b0;
    idle();
    chk("idle_req", req_o, 0);

    // Single ack: pulse at c0, grant at c2.
    cyc(1'b1, 1'b0, 2'b00, 1'b0);
    chk("s_c1_req", req_o, 1);
    chk("s_c1_pend", pending_o, 1);
    idle();
    chk("s_c2_req", req_o, 1);
    grant();
    chk("s_c3_sent", ack_sent_o, 1);
    chk("s_c3_req", req_o, 0);
    chk("s_c3_pend", pending_o, 0);
    idle();
    chk("s_c4_req", req_o, 0);
    chk("s_c4_sent", ack_sent_o, 0);
    idle();
    chk("s_c5_req", req_o, 0);

    // Three back-to-back pulses, then grant whenever requested.
    repeat (3) cyc(1'b1, 1'b0, 2'b00, 1'b0);
    chk("b3_pend", pending_o, 3);
    chk("b3_ovf", overflow_o, 0);
    acks = 0;
    last = -1;
    for (int i = 0; i < 20 && acks < 3; i++) begin
      if (req_o) grant();
      else idle();
      if (ack_sent_o) begin
        acks++;
        chk("b3_gap_req", req_o, 0);
        if (last >= 0) chk("b3_spacing", i - last, 2);
        last = i;
      end
    end
    chk("b3_acks", acks, 3);
    chk("b3_end_pend", pending_o, 0);
    idle();
    chk("b3_end_req", req_o, 0);

    // Overflow: four pulses, no grant.
    repeat (4) cyc(1'b1, 1'b0, 2'b00, 1'b0);
    chk("ovf_pend", pending_o, 3);
    chk("ovf_flag", overflow_o, 1);
    chk("ovf_req", req_o, 1);
    grant();
    chk("ovf_gr_pend", pending_o, 2);

    // Push coincident with grant at pending 2.
    idle();
    chk("pg_req", req_o, 1);
    cyc(1'b1, 1'b1, SID, 1'b1);
    chk("pg_pend", pending_o, 2);
    chk("pg_sent", ack_sent_o, 1);
    idle();
    chk("pg_sent_once", ack_sent_o, 0);

    // READY with the wrong winner ID.
    chk("pe_pre", proto_err_o, 0);
    cyc(1'b0, 1'b1, 2'b10, 1'b1);
    chk("pe_sent", ack_sent_o, 0);
    chk("pe_flag", proto_err_o, 1);
    chk("pe_pend", pending_o, 2);
    chk("pe_req", req_o, 1);

    // Drain the queue.
    for (int i = 0; i < 10 && pending_o != 0; i++) begin
      if (req_o) grant();
      else idle();
    end
    chk("drain_pend", pending_o, 0);
    chk("ovf_sticky", overflow_o, 1);

    // Ungranted request held: timeout after 8 REQ cycles.
    cyc(1'b1, 1'b0, 2'b00, 1'b0);
    repeat (7) idle();
    chk("to_before", timeout_o, 0);
    idle();
`ifdef ACK_REQ_TIMEOUT_EN
    chk("to_set", timeout_o, 1);
`else
    chk("to_off", timeout_o, 0);
`endif
    chk("to_req", req_o, 1);

    // Asynchronous reset mid-REQ.
    #2 rst = 1'b1;
    #1;
    chk("ar_req", req_o, 0);
    chk("ar_pend", pending_o, 0);
    chk("ar_sent", ack_sent_o, 0);
    chk("ar_flags", {overflow_o, proto_err_o, timeout_o}, 0);
    mdl_pend = 0;
    sbq.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();
    chk("ar_after_req", req_o, 0);

    // READY outside REQ is ignored and flagged.
    grant();
    chk("oi_sent", ack_sent_o, 0);
    chk("oi_flag", proto_err_o, 1);
    chk("oi_req", req_o, 0);
    chk("sb_left", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ack_bus_requester.md
ACK_BUS_REQUESTER -- requirements
Module: ack_bus_requester

Interface
REQ-001 SHALL have parameter SOURCE_ID, default 2'b00, meaning the fixed bus ID of the owning module (MEM=00, SHA=01, AES=10, CTRL=11).
REQ-002 SHALL have parameter PEND_W, default 2, meaning the pending-ack counter width (capacity 2^PEND_W-1).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the grant-wait limit used only when ACK_REQ_TIMEOUT_EN is defined.
REQ-004 SHALL have one clock and an asynchronous, active-high reset; ports: clk  input  1  rising-edge clock; rst  input  1  async active-high reset.
REQ-005 SHALL have: ack_pulse_i  input  1  one-cycle pulse, owning module completed one transaction needing an ack.
REQ-006 SHALL have: ack_ready_i  input  1  one-hot READY grant from the ack-bus arbiter for this source.
REQ-007 SHALL have: winner_source_id_i  input  2  broadcast winner ID; ack_event_i  input  1  broadcast ack event.
REQ-008 SHALL have: req_o  output  1  request line to the ack bus.
REQ-009 SHALL have: ack_sent_o  output  1  one-cycle pulse, one ack delivered.
REQ-010 SHALL have: pending_o  output  PEND_W  acks queued, not yet delivered.
REQ-011 SHALL have: overflow_o, proto_err_o, timeout_o  output  1 each  sticky error flags.

Function
REQ-012 SHALL implement FSM states IDLE, REQ, GAP; req_o SHALL be 1 only in REQ, decoded from the state register.
REQ-013 IDLE->REQ when pending_o>0 or ack_pulse_i=1; ack_pulse_i in IDLE with pending 0 SHALL give req_o=1 on the next cycle.
REQ-014 In REQ, grant SHALL be ack_ready_i & ack_event_i & (winner_source_id_i==SOURCE_ID); on grant the next edge SHALL decrement pending, pulse ack_sent_o one cycle, enter GAP.
REQ-015 GAP SHALL last exactly one cycle with req_o=0 (lets lower-priority sources win), then go to REQ if pending>0 else IDLE.
REQ-016 ack_pulse_i SHALL increment pending in every state; simultaneous push and grant SHALL leave pending unchanged.
REQ-017 ack_pulse_i while pending is at capacity and no grant SHALL be dropped, pending unchanged, overflow_o set.
REQ-018 In REQ, ack_ready_i=1 with winner_source_id_i!=SOURCE_ID or ack_event_i=0 SHALL set proto_err_o and SHALL NOT count as a grant.
REQ-019 ack_ready_i outside REQ SHALL be ignored and SHALL set proto_err_o.
REQ-020 Sticky flags SHALL clear only on reset.

Reset
REQ-021 rst=1 SHALL asynchronously force state IDLE, pending_o=0, req_o=0, ack_sent_o=0, all flags 0, timer 0.
REQ-022 Reset during REQ SHALL drop req_o in the same cycle and discard all queued acks.

Configuration
REQ-023 With ACK_REQ_TIMEOUT_EN defined, a timer SHALL count consecutive REQ cycles without grant; on reaching TIMEOUT_CYCLES it SHALL set timeout_o, keep requesting, reset on grant or leaving REQ.
REQ-024 Without ACK_REQ_TIMEOUT_EN, timeout_o SHALL be constant 0 and no timer logic SHALL exist; all other behaviour identical.

Structure
REQ-025 Package ack_bus_pkg SHALL hold ID_MEM/ID_SHA/ID_AES/ID_CTRL constants and the requester state enum, shared with the arbiter top.
REQ-026 Timer SHALL be sub-module ack_req_timer, instantiated only under ACK_REQ_TIMEOUT_EN.

Verification
REQ-027 SOURCE_ID=01; pulse at cycle 0, grant with winner=01 at cycle 2 -> req_o 1 cycles 1-2, ack_sent_o at 3, req_o 0 at 3, IDLE at 4.
REQ-028 Three pulses back-to-back, grant whenever req_o=1 -> pending 3, three ack_sent_o pulses each separated by one GAP cycle, pending 0 at end.
REQ-029 PEND_W=2: four pulses, no grant -> pending 3, overflow_o=1; then grant -> pending 2.
REQ-030 Pulse coincident with grant at pending=2 -> pending stays 2, ack_sent_o pulses once.
REQ-031 ack_ready_i=1 with winner=10 while SOURCE_ID=01 -> no ack_sent_o, proto_err_o=1, pending unchanged.
REQ-032 ACK_REQ_TIMEOUT_EN, TIMEOUT_CYCLES=8: request held 8 cycles ungranted -> timeout_o=1, req_o stays 1; rst mid-REQ -> req_o 0 immediately, all outputs 0.
